// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BLANK_DIGIT = 4'hF;
    localparam bcd_t ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble nibble correction: add 3 to any digit of 5 or more.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  bcd_t nib_i,
    output bcd_t nib_o
);

    assign nib_o = (nib_i >= ADD3_THRESH) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Define BIN2BCD_LZB_EN to replace leading zero digits with the blank code.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  ovf
);

    localparam int unsigned CntW = $clog2(IN_W + 1);
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam logic [CntW-1:0] CntInit = CntW'(IN_W);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IN_W-1:0]     bin_sr_q, bin_sr_d;
    logic [BcdW-1:0]     scratch_q, scratch_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [BcdW-1:0]     digits_q, digits_d;
    logic                ovf_q, ovf_d;

    logic [BcdW-1:0]     corrected;
    logic [BcdW+IN_W:0]  shift_vec;
    logic                shift_out;
    logic [BcdW-1:0]     scratch_sh;
    logic [IN_W-1:0]     bin_sh;
    logic                ovf_final;
    logic                last_shift;
    logic [BcdW-1:0]     result_disp;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (scratch_q[4*g +: 4]),
            .nib_o (corrected[4*g +: 4])
        );
    end

    // Top bit of the corrected scratch is the bit lost off the MSB nibble.
    assign shift_vec  = {corrected, bin_sr_q, 1'b0};
    assign shift_out  = shift_vec[BcdW+IN_W];
    assign scratch_sh = shift_vec[BcdW+IN_W-1:IN_W];
    assign bin_sh     = shift_vec[IN_W-1:0];
    assign ovf_final  = ovf_acc_q | shift_out;
    assign last_shift = (state_q == SHIFT) && (cnt_q == CntOne);

`ifdef BIN2BCD_LZB_EN
    logic seen_nz;

    always_comb begin
        result_disp = scratch_sh;
        seen_nz     = ovf_final;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (!seen_nz && (scratch_sh[4*i +: 4] == 4'd0)) begin
                result_disp[4*i +: 4] = BLANK_DIGIT;
            end else begin
                seen_nz = 1'b1;
            end
        end
    end
`else
    always_comb begin
        result_disp = scratch_sh;
    end
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CntOne) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        bin_sr_d  = bin_sr_q;
        scratch_d = scratch_q;
        ovf_acc_d = ovf_acc_q;
        digits_d  = digits_q;
        ovf_d     = ovf_q;
        if ((state_q == IDLE) && start) begin
            bin_sr_d  = bin;
            scratch_d = '0;
            ovf_acc_d = 1'b0;
            cnt_d     = CntInit;
        end else if (state_q == SHIFT) begin
            scratch_d = scratch_sh;
            bin_sr_d  = bin_sh;
            ovf_acc_d = ovf_final;
            cnt_d     = cnt_q - CntOne;
            if (last_shift) begin
                digits_d = result_disp;
                ovf_d    = ovf_final;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            bin_sr_q  <= '0;
            scratch_q <= '0;
            ovf_acc_q <= 1'b0;
            digits_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bin_sr_q  <= bin_sr_d;
            scratch_q <= scratch_d;
            ovf_acc_q <= ovf_acc_d;
            digits_q  <= digits_d;
            ovf_q     <= ovf_d;
        end
    end

    assign digits = digits_q;
    assign ovf    = ovf_q;

endmodule
